// File: rtl/hash_arbiter.sv
// Two-requester arbiter in front of one shared SHA core: round-robin on ties, one request in flight.
// Optional WAIT-state watchdog enabled by defining HASH_ARB_WATCHDOG_EN.
module hash_arbiter #(
    parameter int unsigned KEY_LEN        = 256,
    parameter int unsigned WATCHDOG_LIMIT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a_start,
    input  logic [1023:0]      a_data_in,
    input  logic               a_message_length,
    output logic               a_done,
    output logic               a_pending,
    input  logic               b_start,
    input  logic [1023:0]      b_data_in,
    input  logic               b_message_length,
    output logic               b_done,
    output logic               b_pending,
    output logic [KEY_LEN-1:0] data_out,
    output logic               hash_start,
    output logic [1023:0]      hash_data_in,
    output logic               hash_message_length,
    input  logic               hash_done,
    input  logic [KEY_LEN-1:0] hash_data_out,
    output logic               busy,
    output logic               error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_grant_q, last_grant_d;
    logic   a_pending_q, a_pending_d;
    logic   b_pending_q, b_pending_d;
    logic   error_q, error_d;
    logic   finish;
    logic   abort;
    logic   a_clear, b_clear;

`ifdef HASH_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WATCHDOG_LIMIT + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        finish       = 1'b0;
        abort        = 1'b0;
`ifdef HASH_ARB_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (a_pending_q || b_pending_q) begin
                    state_d = ST_ISSUE;
                    if (a_pending_q && b_pending_q) owner_d = ~last_grant_q;
                    else                            owner_d = b_pending_q;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef HASH_ARB_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (hash_done) begin
                    finish       = 1'b1;
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end
`ifdef HASH_ARB_WATCHDOG_EN
                // Abort is decided in the LIMIT-th WAIT cycle so error appears after exactly LIMIT cycles.
                else if (wd_cnt_q == WD_W'(WATCHDOG_LIMIT - 1)) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion frees the owner's slot in the same cycle, so a restart then is a fresh request.
    always_comb begin
        a_clear     = (finish || abort) && !owner_q;
        b_clear     = (finish || abort) && owner_q;
        a_pending_d = a_pending_q && !a_clear;
        b_pending_d = b_pending_q && !b_clear;
        error_d     = error_q || abort;
        if (a_start) begin
            if (a_pending_d) error_d     = 1'b1;
            else             a_pending_d = 1'b1;
        end
        if (b_start) begin
            if (b_pending_d) error_d     = 1'b1;
            else             b_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_pending_q  <= 1'b0;
            b_pending_q  <= 1'b0;
            error_q      <= 1'b0;
`ifdef HASH_ARB_WATCHDOG_EN
            wd_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            a_pending_q  <= a_pending_d;
            b_pending_q  <= b_pending_d;
            error_q      <= error_d;
`ifdef HASH_ARB_WATCHDOG_EN
            wd_cnt_q     <= wd_cnt_d;
`endif
        end
    end

    // Strobes are gated by reset so an in-flight request is dropped silently while reset is low.
    always_comb begin
        a_done              = reset && finish && !owner_q;
        b_done              = reset && finish && owner_q;
        hash_start          = reset && (state_q == ST_ISSUE);
        busy                = reset && (state_q != ST_IDLE);
        hash_data_in        = '0;
        hash_message_length = 1'b0;
        if (reset && (state_q != ST_IDLE)) begin
            hash_data_in        = owner_q ? b_data_in        : a_data_in;
            hash_message_length = owner_q ? b_message_length : a_message_length;
        end
    end

    assign a_pending = a_pending_q;
    assign b_pending = b_pending_q;
    assign error     = error_q;
    assign data_out  = hash_data_out;

endmodule

// File: tb/tb_hash_arbiter.sv
// Directed self-checking bench for hash_arbiter; the bench itself plays the SHA core.
// Watchdog scenario runs only when HASH_ARB_WATCHDOG_EN is defined.
module tb_hash_arbiter;

    localparam int unsigned KEY_LEN = 256;
    localparam logic [1023:0] A_MSG = {16{64'h0123_4567_89AB_CDEF}};
    localparam logic [1023:0] B_MSG = {16{64'hFEDC_BA98_7654_3210}};
    localparam logic [255:0]  A_LO  = A_MSG[255:0];
    localparam logic [255:0]  B_LO  = B_MSG[255:0];
    localparam logic [255:0]  DIG_AB = {32{8'hAB}};
    localparam logic [255:0]  DIG_1  = {8{32'h1357_9BDF}};
    localparam logic [255:0]  DIG_2  = {8{32'h2468_ACE0}};

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               a_start = 1'b0, b_start = 1'b0;
    logic [1023:0]      a_data_in = A_MSG, b_data_in = B_MSG;
    logic               a_message_length = 1'b1, b_message_length = 1'b0;
    logic               a_done, a_pending, b_done, b_pending;
    logic [KEY_LEN-1:0] data_out;
    logic               hash_start;
    logic [1023:0]      hash_data_in;
    logic               hash_message_length;
    logic               hash_done = 1'b0;
    logic [KEY_LEN-1:0] hash_data_out = '0;
    logic               busy, error;

    int n_checks = 0;
    int n_fail   = 0;
    logic stray;

    always #5 clk = ~clk;

    hash_arbiter #(
        .KEY_LEN        (KEY_LEN),
        .WATCHDOG_LIMIT (15)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .a_start             (a_start),
        .a_data_in           (a_data_in),
        .a_message_length    (a_message_length),
        .a_done              (a_done),
        .a_pending           (a_pending),
        .b_start             (b_start),
        .b_data_in           (b_data_in),
        .b_message_length    (b_message_length),
        .b_done              (b_done),
        .b_pending           (b_pending),
        .data_out            (data_out),
        .hash_start          (hash_start),
        .hash_data_in        (hash_data_in),
        .hash_message_length (hash_message_length),
        .hash_done           (hash_done),
        .hash_data_out       (hash_data_out),
        .busy                (busy),
        .error               (error)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; a_start = 1'b0; b_start = 1'b0; hash_done = 1'b0;
        step();
        step();
        #1;
        check("rst_busy",   256'(busy), 256'd0);
        check("rst_hstart", 256'(hash_start), 256'd0);
        check("rst_done",   256'({a_done, b_done}), 256'd0);
        check("rst_hdata",  hash_data_in[255:0], 256'd0);
        check("rst_hlen",   256'(hash_message_length), 256'd0);
        check("rst_pend",   256'({a_pending, b_pending}), 256'd0);
        check("rst_err",    256'(error), 256'd0);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Single request from A with a 40-cycle core latency.
        do_reset();
        a_start = 1'b1;
        step();
        a_start = 1'b0; #1;
        check("t1_pend", 256'(a_pending), 256'd1);
        check("t1_nostart", 256'(hash_start), 256'd0);
        step(); #1;
        check("t1_hstart", 256'(hash_start), 256'd1);
        check("t1_busy",   256'(busy), 256'd1);
        check("t1_hdata",  hash_data_in[255:0], A_LO);
        check("t1_hlen",   256'(hash_message_length), 256'd1);
        step();
        stray = 1'b0;
        for (int i = 0; i < 39; i++) begin
            #1;
            stray = stray | a_done | b_done | hash_start;
            step();
        end
        hash_done = 1'b1; hash_data_out = DIG_AB; #1;
        check("t1_stray", 256'(stray), 256'd0);
        check("t1_adone", 256'(a_done), 256'd1);
        check("t1_bdone", 256'(b_done), 256'd0);
        check("t1_dout",  data_out, DIG_AB);
        step();
        hash_done = 1'b0; #1;
        check("t1_after", 256'({a_done, a_pending, busy}), 256'd0);

        // Simultaneous starts after reset: A first, then B.
        do_reset();
        a_start = 1'b1; b_start = 1'b1;
        step();
        a_start = 1'b0; b_start = 1'b0; #1;
        check("t2_pend", 256'({a_pending, b_pending}), 256'b11);
        step(); #1;
        check("t2_hdata_a", hash_data_in[255:0], A_LO);
        check("t2_hlen_a",  256'(hash_message_length), 256'd1);
        step();
        hash_done = 1'b1; hash_data_out = DIG_1; #1;
        check("t2_adone", 256'({a_done, b_done}), 256'b10);
        check("t2_dout",  data_out, DIG_1);
        step();
        hash_done = 1'b0; #1;
        check("t2_idle", 256'({busy, hash_start, b_pending}), 256'b001);
        step(); #1;
        check("t2_hstart_b", 256'(hash_start), 256'd1);
        check("t2_hdata_b",  hash_data_in[255:0], B_LO);
        check("t2_hlen_b",   256'(hash_message_length), 256'd0);
        step();
        hash_done = 1'b1; hash_data_out = DIG_2; #1;
        check("t2_bdone", 256'({a_done, b_done}), 256'b01);
        step();
        hash_done = 1'b0;

        // Tie again with last_grant=B: A wins; A restarts in its done cycle.
        a_start = 1'b1; b_start = 1'b1;
        step();
        a_start = 1'b0; b_start = 1'b0;
        step(); #1;
        check("t3_tie_a", hash_data_in[255:0], A_LO);
        step();
        hash_done = 1'b1; a_start = 1'b1; #1;
        check("t3_adone", 256'(a_done), 256'd1);
        step();
        hash_done = 1'b0; a_start = 1'b0; #1;
        check("t3_noerr", 256'({error, a_pending, b_pending}), 256'b011);
        step(); #1;
        check("t3_b_next", hash_data_in[255:0], B_LO);
        step();
        hash_done = 1'b1; #1;
        check("t3_bdone", 256'({a_done, b_done}), 256'b01);
        step();
        hash_done = 1'b0;
        step(); #1;
        check("t3_a_again", hash_data_in[255:0], A_LO);
        step();
        hash_done = 1'b1; #1;
        check("t3_adone2", 256'({a_done, b_done}), 256'b10);
        step();
        hash_done = 1'b0; #1;
        check("t3_end", 256'({error, busy, a_pending, b_pending}), 256'd0);

        // hash_done while idle is ignored.
        hash_done = 1'b1; #1;
        check("t4_idle_done", 256'({a_done, b_done}), 256'd0);
        step();
        hash_done = 1'b0; #1;
        check("t4_idle_busy", 256'(busy), 256'd0);

        // B owns the core; A starts twice meanwhile.
        do_reset();
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        step();
        step();
        a_start = 1'b1;
        step();
        a_start = 1'b0; #1;
        check("t5_a_acc", 256'({a_pending, error}), 256'b10);
        a_start = 1'b1;
        step();
        a_start = 1'b0; #1;
        check("t5_err", 256'(error), 256'd1);
        step();
        hash_done = 1'b1; #1;
        check("t5_bdone", 256'({a_done, b_done}), 256'b01);
        step();
        hash_done = 1'b0;
        step(); #1;
        check("t5_a_served", hash_data_in[255:0], A_LO);
        step();
        hash_done = 1'b1; #1;
        check("t5_adone", 256'(a_done), 256'd1);
        step();
        hash_done = 1'b0;
        step();
        step(); #1;
        check("t5_once", 256'({hash_start, busy, a_pending}), 256'd0);
        check("t5_sticky", 256'(error), 256'd1);

        // Reset during WAIT drops the request without a done pulse.
        do_reset();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
        step();
        step();
        reset = 1'b0; hash_done = 1'b1; #1;
        check("t6_nodone", 256'({a_done, b_done}), 256'd0);
        step();
        reset = 1'b1; hash_done = 1'b0; #1;
        check("t6_clear", 256'({busy, a_pending, hash_start}), 256'd0);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        step(); #1;
        check("t6_restart", 256'(hash_start), 256'd1);
        step();
        hash_done = 1'b1; hash_data_out = DIG_2; #1;
        check("t6_adone", 256'(a_done), 256'd1);
        check("t6_dout",  data_out, DIG_2);
        step();
        hash_done = 1'b0;

`ifdef HASH_ARB_WATCHDOG_EN
        // Core never answers: abort after 15 WAIT cycles.
        do_reset();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
        step();
        stray = 1'b0;
        for (int i = 0; i < 14; i++) begin
            #1;
            stray = stray | a_done | error;
            step();
        end
        #1;
        check("wd_pre", 256'({stray, error, busy}), 256'b001);
        step(); #1;
        check("wd_abort", 256'({error, busy, a_pending, a_done}), 256'b1000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
